// File: rtl/wb_resp_pkg.sv
// Shared types and widths for the Wishbone register responder.
package wb_resp_pkg;
  localparam int WB_DATA_W     = 32;
  localparam int WB_SEL_W      = 4;
  localparam int WB_WAIT_CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} wb_resp_state_t;
endpackage

// File: rtl/wb_byte_merge.sv
// Combinational byte-lane merge: lanes with sel set take the new word, others keep the old word.
module wb_byte_merge
  import wb_resp_pkg::*;
(
  input  logic [WB_DATA_W-1:0] old_word,
  input  logic [WB_DATA_W-1:0] new_word,
  input  logic [WB_SEL_W-1:0]  sel,
  output logic [WB_DATA_W-1:0] merged_word
);
  genvar gi;
  generate
    for (gi = 0; gi < WB_SEL_W; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = sel[gi] ? new_word[8*gi +: 8] : old_word[8*gi +: 8];
    end
  endgenerate
endmodule

// File: rtl/wishbone_reg_responder.sv
// Wishbone B4 classic register bank with programmable wait states before acknowledge.
// Optional macro WB_RESP_ERR_EN adds wbs_err_o, raised instead of ack for out-of-range accesses.
module wishbone_reg_responder
  import wb_resp_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [WB_SEL_W-1:0]     wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [WB_DATA_W-1:0]    wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [WB_DATA_W-1:0]    wbs_dat_o,
`ifdef WB_RESP_ERR_EN
  output logic                    wbs_err_o,
`endif
  output logic [32*NUM_REGS-1:0]  regs_o
);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [WB_WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WB_WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  wb_resp_state_t             state_reg, state_next;
  logic [WB_WAIT_CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic                       we_reg;
  logic [WB_SEL_W-1:0]        sel_reg;
  logic [IDX_W-1:0]           idx_reg;
  logic [WB_DATA_W-1:0]       wdata_reg;
  logic                       in_range_reg;
  logic                       ack_reg;
  logic [WB_DATA_W-1:0]       rdata_reg;
  logic [WB_DATA_W-1:0]       regs_reg [NUM_REGS];

  logic                       req;
  logic [31:0]                bus_off;
  logic                       bus_in_range;
  logic [IDX_W-1:0]           bus_idx;
  logic                       use_bus;
  logic                       cur_we;
  logic [WB_SEL_W-1:0]        cur_sel;
  logic [IDX_W-1:0]           cur_idx;
  logic [WB_DATA_W-1:0]       cur_wdata;
  logic                       cur_in_range;
  logic [WB_DATA_W-1:0]       cur_word;
  logic [WB_DATA_W-1:0]       merged_word;
  logic                       enter_ack;
  logic                       resp_ok;
  logic                       wr_en;
  logic                       unused_adr_bits;

  assign req     = wbs_cyc_i & wbs_stb_i;
  assign bus_off = wbs_adr_i - BASE_ADDR;
  assign bus_in_range = (wbs_adr_i >= BASE_ADDR) && ({2'b00, bus_off[31:2]} < 32'(NUM_REGS));
  assign bus_idx = bus_off[IDX_W+1:2];
  assign unused_adr_bits = ^bus_off[1:0];

  // With zero wait states ACK is entered on the capture edge, so the live bus
  // values stand in for the captured ones while in IDLE.
  assign use_bus      = (state_reg == IDLE);
  assign cur_we       = use_bus ? wbs_we_i     : we_reg;
  assign cur_sel      = use_bus ? wbs_sel_i    : sel_reg;
  assign cur_idx      = use_bus ? bus_idx      : idx_reg;
  assign cur_wdata    = use_bus ? wbs_dat_i    : wdata_reg;
  assign cur_in_range = use_bus ? bus_in_range : in_range_reg;
  assign cur_word     = regs_reg[cur_idx];

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    enter_ack     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_next    = WAIT;
            wait_cnt_next = WAIT_LOAD;
          end else begin
            state_next = ACK;
            enter_ack  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_next    = IDLE;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == '0) begin
          state_next = ACK;
          enter_ack  = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg - 1'b1;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef WB_RESP_ERR_EN
  logic err_reg;
  assign resp_ok   = cur_in_range;
  assign wbs_err_o = err_reg;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) err_reg <= 1'b0;
    else          err_reg <= enter_ack & ~cur_in_range;
  end
`else
  assign resp_ok = 1'b1;
`endif

  assign wr_en = enter_ack & cur_we & cur_in_range;

  wb_byte_merge u_merge (
    .old_word    (cur_word),
    .new_word    (cur_wdata),
    .sel         (cur_sel),
    .merged_word (merged_word)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      we_reg       <= 1'b0;
      sel_reg      <= '0;
      idx_reg      <= '0;
      wdata_reg    <= '0;
      in_range_reg <= 1'b0;
      ack_reg      <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_reg == IDLE && req) begin
        we_reg       <= wbs_we_i;
        sel_reg      <= wbs_sel_i;
        idx_reg      <= bus_idx;
        wdata_reg    <= wbs_dat_i;
        in_range_reg <= bus_in_range;
      end
      ack_reg   <= enter_ack & resp_ok;
      rdata_reg <= (enter_ack && !cur_we && cur_in_range) ? cur_word : '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int k = 0; k < NUM_REGS; k++) regs_reg[k] <= '0;
    end else if (wr_en) begin
      regs_reg[cur_idx] <= merged_word;
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = rdata_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
      assign regs_o[32*gi +: 32] = regs_reg[gi];
    end
  endgenerate
endmodule

// File: tb/tb_wishbone_reg_responder.sv
// Directed bench: instance 0 has no wait states, instance 1 has three; reads are scoreboarded.
module tb_wishbone_reg_responder;
  localparam int          NREGS = 8;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic tb_CLK = 1'b0;
  always #5 tb_CLK = ~tb_CLK;

  logic              rst  [2];
  logic              cyc  [2];
  logic              stb  [2];
  logic              we   [2];
  logic [3:0]        sel  [2];
  logic [31:0]       adr  [2];
  logic [31:0]       wdat [2];
  logic [31:0]       rdat [2];
  logic              ack  [2];
  logic              err  [2];
  logic [32*NREGS-1:0] regs [2];

  logic [31:0] model [2][NREGS];
  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  wishbone_reg_responder #(.NUM_REGS(NREGS), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
    .wb_clk_i(tb_CLK), .wb_rst_i(rst[0]), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]),
    .wbs_we_i(we[0]), .wbs_sel_i(sel[0]), .wbs_adr_i(adr[0]), .wbs_dat_i(wdat[0]),
    .wbs_ack_o(ack[0]), .wbs_dat_o(rdat[0]),
`ifdef WB_RESP_ERR_EN
    .wbs_err_o(err[0]),
`endif
    .regs_o(regs[0])
  );

  wishbone_reg_responder #(.NUM_REGS(NREGS), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut1 (
    .wb_clk_i(tb_CLK), .wb_rst_i(rst[1]), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]),
    .wbs_we_i(we[1]), .wbs_sel_i(sel[1]), .wbs_adr_i(adr[1]), .wbs_dat_i(wdat[1]),
    .wbs_ack_o(ack[1]), .wbs_dat_o(rdat[1]),
`ifdef WB_RESP_ERR_EN
    .wbs_err_o(err[1]),
`endif
    .regs_o(regs[1])
  );

`ifndef WB_RESP_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all_regs(input int d, input string tag);
    for (int k = 0; k < NREGS; k++)
      check($sformatf("%s_reg%0d", tag, k), regs[d][32*k +: 32], model[d][k]);
  endtask

  // One complete bus transfer; the expected read word is queued at drive time.
  task automatic xfer(input int d, input logic w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] v, input int exp_lat, input string tag);
    logic [31:0] off;
    logic        inr;
    logic        exp_err;
    int          idx;
    int          lat;
    logic        done;
    logic [31:0] expd;
    off = a - BASE;
    inr = (a >= BASE) && (off[31:2] < 30'(NREGS));
    idx = inr ? int'(off[31:2]) : 0;
`ifdef WB_RESP_ERR_EN
    exp_err = !inr;
`else
    exp_err = 1'b0;
`endif
    if (!w) exp_q.push_back(inr ? model[d][idx] : 32'h0);
    else if (inr)
      for (int i = 0; i < 4; i++)
        if (s[i]) model[d][idx][8*i +: 8] = v[8*i +: 8];
    @(posedge tb_CLK); #1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; wdat[d] = v;
    lat = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge tb_CLK); #1;
      lat++;
      // bus inputs after capture must not matter
      adr[d] = 32'hFFFF_FFFC; wdat[d] = 32'h5555_5555; sel[d] = 4'hF;
      if (ack[d] || err[d]) done = 1'b1;
      else check({tag, "_dat_idle"}, rdat[d], 32'h0);
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    if (!done) begin
      check({tag, "_timeout"}, 32'(lat), 32'(exp_lat));
    end else begin
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_ack"}, 32'(ack[d]), 32'(!exp_err));
      check({tag, "_err"}, 32'(err[d]), 32'(exp_err));
      if (!w) begin
        expd = exp_q.pop_front();
        $display("xfer %s dut%0d read  adr=%h dat=%h exp=%h lat=%0d", tag, d, a, rdat[d], expd, lat);
        check({tag, "_rdata"}, rdat[d], expd);
      end else begin
        $display("xfer %s dut%0d write adr=%h dat=%h sel=%h lat=%0d", tag, d, a, v, s, lat);
        check_all_regs(d, tag);
      end
    end
    @(posedge tb_CLK); #1;
    check({tag, "_ack_pulse"}, 32'(ack[d]), 32'h0);
    check({tag, "_dat_after"}, rdat[d], 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      sel[d] = 4'h0; adr[d] = 32'h0; wdat[d] = 32'h0;
      for (int k = 0; k < NREGS; k++) model[d][k] = 32'h0;
    end
    repeat (2) @(posedge tb_CLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_ack%0d", d), 32'(ack[d]), 32'h0);
      check($sformatf("reset_err%0d", d), 32'(err[d]), 32'h0);
      check($sformatf("reset_dat%0d", d), rdat[d], 32'h0);
      check_all_regs(d, $sformatf("reset%0d", d));
    end
    rst[0] = 1'b0; rst[1] = 1'b0;

    // zero wait states
    xfer(0, 1'b1, 4'hF, BASE + 32'd4, 32'hDEADBEEF, 1, "w_full");
    xfer(0, 1'b0, 4'h0, BASE + 32'd4, 32'h0, 1, "r_full");
    xfer(0, 1'b1, 4'b0101, BASE + 32'd4, 32'h11223344, 1, "w_sel5");
    xfer(0, 1'b0, 4'h1, BASE + 32'd4, 32'h0, 1, "r_sel5");
    xfer(0, 1'b1, 4'b0000, BASE + 32'd4, 32'hFFFFFFFF, 1, "w_sel0");
    xfer(0, 1'b0, 4'hF, BASE + 32'd4, 32'h0, 1, "r_sel0");
    xfer(0, 1'b1, 4'hF, BASE + 32'd31, 32'h12345678, 1, "w_last");
    xfer(0, 1'b0, 4'hF, BASE + 32'd28, 32'h0, 1, "r_last");
    xfer(0, 1'b1, 4'hF, BASE + 32'd32, 32'hFFFFFFFF, 1, "w_oor");
    xfer(0, 1'b0, 4'hF, BASE + 32'd32, 32'h0, 1, "r_oor");
    xfer(0, 1'b0, 4'hF, BASE - 32'd4, 32'h0, 1, "r_below");

    // three wait states
    xfer(1, 1'b0, 4'hF, BASE, 32'h0, 4, "r_ws3");
    xfer(1, 1'b1, 4'hF, BASE + 32'd8, 32'hCAFEF00D, 4, "w_ws3");
    xfer(1, 1'b0, 4'hF, BASE + 32'd8, 32'h0, 4, "rb_ws3");

    // strobe dropped in WAIT
    @(posedge tb_CLK); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF;
    adr[1] = BASE + 32'd8; wdat[1] = 32'hA5A5A5A5;
    repeat (2) @(posedge tb_CLK);
    #1;
    stb[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge tb_CLK); #1;
      check($sformatf("abort_noack%0d", i), 32'(ack[1]), 32'h0);
    end
    cyc[1] = 1'b0;
    $display("xfer abort dut1 write adr=%h dropped", BASE + 32'd8);
    check_all_regs(1, "abort");
    xfer(1, 1'b0, 4'hF, BASE + 32'd8, 32'h0, 4, "r_after_abort");

    // reset during WAIT of a write
    @(posedge tb_CLK); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF;
    adr[1] = BASE + 32'd12; wdat[1] = 32'h0BADF00D;
    repeat (2) @(posedge tb_CLK);
    #1;
    rst[1] = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
    @(posedge tb_CLK); #1;
    for (int k = 0; k < NREGS; k++) model[1][k] = 32'h0;
    check("rst_mid_ack", 32'(ack[1]), 32'h0);
    check_all_regs(1, "rst_mid");
    rst[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge tb_CLK); #1;
      check($sformatf("rst_noack%0d", i), 32'(ack[1]), 32'h0);
    end
    $display("xfer reset dut1 write adr=%h discarded", BASE + 32'd12);
    xfer(1, 1'b1, 4'hF, BASE + 32'd12, 32'h13579BDF, 4, "w_after_rst");
    xfer(1, 1'b0, 4'hF, BASE + 32'd12, 32'h0, 4, "r_after_rst");

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wishbone_reg_responder.md
# wishbone_reg_responder

Wishbone B4 classic subordinate exposing a bank of 32-bit read/write registers to the bus, with a programmable number of wait states before acknowledge. It sits on one `wishbone_decoder` peripheral slot, the same slot position as the SRAM and GPIO control wrappers, and answers the `wishbone_manager` initiators through the arbitrator. Register contents are also driven out in parallel so design logic can consume them directly.

## Interface
- `NUM_REGS`, 8: number of 32-bit registers; at least 1.
- `BASE_ADDR`, 32'h3000_0000: byte address of register 0; word-aligned.
- `WAIT_STATES`, 0: cycles inserted between request capture and ack; 0..15.
- `wb_clk_i`  in  1  bus clock; single clock domain.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `wbs_cyc_i`  in  1  bus cycle valid.
- `wbs_stb_i`  in  1  strobe.
- `wbs_we_i`  in  1  1 = write, 0 = read.
- `wbs_sel_i`  in  4  byte-lane enables; bit i covers data bits [8i+7:8i].
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  transfer acknowledge; one-cycle pulse.
- `wbs_dat_o`  out  32  read data; valid only while ack is high, 0 otherwise.
- `regs_o`  out  32*NUM_REGS  register contents; register k is at bits [32k+31:32k].

## Operation
- Request = `wbs_cyc_i & wbs_stb_i`, sampled on the rising edge in IDLE.
- Index = (`wbs_adr_i` - BASE_ADDR) >> 2. An address is in range when it is at or above BASE_ADDR and the index is below NUM_REGS. Address bits [1:0] are ignored.
- States:
  - IDLE: on a request, capture we/sel/index/data. Go to WAIT if WAIT_STATES > 0, otherwise go to ACK.
  - WAIT: count down from WAIT_STATES-1. Go to ACK when the count is 0. If the request drops, abort to IDLE: no write, no ack.
  - ACK: ack high for exactly one cycle, then go to IDLE unconditionally.
- Writes commit on the edge that enters ACK. Only lanes with `sel` set are updated. `sel` = 4'b0000 is still acknowledged and changes nothing.
- Reads return the full 32-bit word regardless of `sel`. The value is the register content at the edge entering ACK.
- Out-of-range address: a write is dropped, a read returns 32'h0, and the transfer is still acked.
- The request is re-checked before ack: if cyc or stb is low on the edge that would enter ACK, go to IDLE instead.
- Captured address and data are used, so changes to the bus inputs after capture are ignored.

## Timing
- Reset values: `wbs_ack_o` = 0, `wbs_dat_o` = 0, all registers 0, so `regs_o` = 0, FSM = IDLE, wait counter = 0.
- Latency: ack is high WAIT_STATES+1 cycles after the edge that captures the request. With WAIT_STATES = 0, ack rises on the cycle after stb is first seen.
- Throughput: minimum WAIT_STATES+2 cycles per transfer, because there is one mandatory IDLE cycle after ACK. A strobe still high in that IDLE cycle is treated as a new request.
- `regs_o` updates on the same edge that raises ack for a write.
- Reset asserted mid-transfer: next edge gives IDLE with ack low, and the pending write is discarded.
- Reset has priority over every other event.

## Configuration
- `WB_RESP_ERR_EN` defined:
  - Adds output `wbs_err_o` (1 bit, reset 0).
  - An out-of-range access raises `wbs_err_o` instead of `wbs_ack_o`, with the same timing and one-cycle width, and `wbs_dat_o` = 0.
- Undefined:
  - No `wbs_err_o` port.
  - Out-of-range accesses are acked as described in Operation.

## Structure
- `wb_resp_pkg`:
  - `typedef enum logic [1:0] {IDLE, WAIT, ACK} wb_resp_state_t`.
  - Constants `WB_DATA_W` = 32, `WB_SEL_W` = 4, `WB_WAIT_CNT_W` = 4.
- Sub-module `wb_byte_merge`: combinational merge of old word, new word and sel into the write value. It is instantiated once, and all state remains in the top module.

## Test plan
- Write 32'hDEADBEEF to BASE_ADDR+4 with sel 4'hF, WAIT_STATES = 0 -> ack 1 cycle after capture, register 1 bits of `regs_o` = 32'hDEADBEEF; a read of BASE_ADDR+4 returns 32'hDEADBEEF with ack.
- Register 1 = 32'hDEADBEEF, write 32'h11223344 with sel 4'b0101 -> register 1 = 32'hDE22BE44; sel 4'b0000 -> acked, value unchanged.
- WAIT_STATES = 3, read register 0 -> ack high exactly 4 cycles after capture, for one cycle; `wbs_dat_o` = 0 outside ack.
- Drop stb during WAIT of a write of 32'hA5A5A5A5 -> no ack, register unchanged, FSM back in IDLE next cycle.
- Access BASE_ADDR + 4*NUM_REGS -> write ignored, read returns 0 with ack; with `WB_RESP_ERR_EN`, `wbs_err_o` pulses and ack stays low.
- Assert `wb_rst_i` in the WAIT state of a write -> ack never rises, all of `regs_o` = 0, and the next transfer completes normally.
